// File: rtl/dca_lsu_txn_splitter.sv
// Transaction-info splitter for the matrix LSU. Descriptors {last, chain, alen, bitaddr} whose
// burst exceeds MAX_ALEN+1 beats are cut into AXI-legal sub-bursts with advancing addresses.
// All emitted descriptors are buffered in a small FIFO toward the address channel.
module dca_lsu_txn_splitter #(
   parameter int BW_BITADDR  = 32,
   parameter int BW_ALEN     = 8,
   parameter int BW_BEAT     = 32,
   parameter int MAX_ALEN    = 15,
   parameter int SPLIT_EN    = 1,
   parameter int FIFO_DEPTH  = 4,
   localparam int BW_TXN_INFO = BW_BITADDR + BW_ALEN + 2
) (
   input  logic                   clk,
   input  logic                   rstnn,
   input  logic                   clear,
   input  logic                   enable,
   output logic                   sinfo_ready,
   input  logic                   sinfo_valid,
   input  logic [BW_TXN_INFO-1:0] sinfo,
   output logic                   minfo_ready,
   output logic [BW_TXN_INFO-1:0] minfo,
   input  logic                   minfo_request,
   output logic                   busy,
   output logic [15:0]            split_count
);

   localparam int LP_PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int LP_CNT_W = $clog2(FIFO_DEPTH + 1);

   localparam logic [0:0] LP_ST_IDLE  = 1'b0;
   localparam logic [0:0] LP_ST_SPLIT = 1'b1;

   localparam logic [BW_ALEN-1:0]    LP_MAX_ALEN  = BW_ALEN'(MAX_ALEN);
   localparam logic [BW_ALEN-1:0]    LP_STEP_ALEN = BW_ALEN'(MAX_ALEN + 1);
   localparam logic [BW_BITADDR-1:0] LP_ADDR_STEP = BW_BITADDR'((MAX_ALEN + 1) * BW_BEAT);
   localparam logic [LP_CNT_W-1:0]   LP_FULL_CNT  = LP_CNT_W'(FIFO_DEPTH);
   localparam logic [LP_PTR_W-1:0]   LP_LAST_PTR  = LP_PTR_W'(FIFO_DEPTH - 1);

   // Split state
   logic [0:0]            r_state;
   logic [BW_ALEN-1:0]    r_rem_alen;
   logic [BW_BITADDR-1:0] r_next_addr;
   logic                  r_last;
   logic                  r_chain;
   logic [15:0]           r_split_count;

   // Output FIFO
   logic [BW_TXN_INFO-1:0] r_mem [FIFO_DEPTH];
   logic [LP_PTR_W-1:0]    r_wptr;
   logic [LP_PTR_W-1:0]    r_rptr;
   logic [LP_CNT_W-1:0]    r_count;

   logic                   w_run;
   logic                   w_fifo_wready;
   logic                   w_accept;
   logic                   w_pop;
   logic                   w_s_last;
   logic                   w_s_chain;
   logic [BW_ALEN-1:0]     w_s_alen;
   logic [BW_BITADDR-1:0]  w_s_addr;
   logic                   w_s_split;
   logic                   w_r_more;

   logic                   w_push;
   logic [BW_TXN_INFO-1:0] w_push_data;
   logic [0:0]             w_state_d;
   logic [BW_ALEN-1:0]     w_rem_alen_d;
   logic [BW_BITADDR-1:0]  w_next_addr_d;
   logic                   w_last_d;
   logic                   w_chain_d;
   logic                   w_split_inc;

   assign w_s_last  = sinfo[BW_TXN_INFO-1];
   assign w_s_chain = sinfo[BW_TXN_INFO-2];
   assign w_s_alen  = sinfo[BW_BITADDR +: BW_ALEN];
   assign w_s_addr  = sinfo[BW_BITADDR-1:0];

   assign w_run         = enable & ~clear;
   assign w_fifo_wready = (r_count != LP_FULL_CNT);
   // rstnn gates ready so nothing is offered while the block is held in reset
   assign sinfo_ready   = rstnn & w_run & w_fifo_wready & (r_state == LP_ST_IDLE);
   assign w_accept      = sinfo_valid & sinfo_ready;
   assign w_pop         = w_run & minfo_request & (r_count != '0);
   assign w_s_split     = (SPLIT_EN != 0) && (w_s_alen > LP_MAX_ALEN);
   // Compare before subtract, so the remainder can never underflow
   assign w_r_more      = (r_rem_alen > LP_MAX_ALEN);

   assign minfo_ready = (r_count != '0);
   assign minfo       = minfo_ready ? r_mem[r_rptr] : '0;
   assign busy        = (r_state == LP_ST_SPLIT) | minfo_ready;
   assign split_count = r_split_count;

   // Next-state and push selection for the IDLE/SPLIT machine
   always_comb begin
      w_push        = 1'b0;
      w_push_data   = sinfo;
      w_state_d     = r_state;
      w_rem_alen_d  = r_rem_alen;
      w_next_addr_d = r_next_addr;
      w_last_d      = r_last;
      w_chain_d     = r_chain;
      w_split_inc   = 1'b0;
      case (r_state)
         LP_ST_IDLE: begin
            if (w_accept) begin
               w_push = 1'b1;
               if (w_s_split) begin
                  w_push_data   = {1'b0, 1'b1, LP_MAX_ALEN, w_s_addr};
                  w_rem_alen_d  = w_s_alen - LP_STEP_ALEN;
                  w_next_addr_d = w_s_addr + LP_ADDR_STEP;
                  w_last_d      = w_s_last;
                  w_chain_d     = w_s_chain;
                  w_split_inc   = 1'b1;
                  w_state_d     = LP_ST_SPLIT;
               end
            end
         end
         LP_ST_SPLIT: begin
            if (w_run && w_fifo_wready) begin
               w_push = 1'b1;
               if (w_r_more) begin
                  w_push_data   = {1'b0, 1'b1, LP_MAX_ALEN, r_next_addr};
                  w_rem_alen_d  = r_rem_alen - LP_STEP_ALEN;
                  w_next_addr_d = r_next_addr + LP_ADDR_STEP;
                  w_split_inc   = 1'b1;
               end else begin
                  w_push_data = {r_last, r_chain, r_rem_alen, r_next_addr};
                  w_state_d   = LP_ST_IDLE;
               end
            end
         end
         default: w_state_d = LP_ST_IDLE;
      endcase
   end

   // Split state registers; clear discards any remainder
   always_ff @(posedge clk or negedge rstnn) begin
      if (!rstnn) begin
         r_state     <= LP_ST_IDLE;
         r_rem_alen  <= '0;
         r_next_addr <= '0;
         r_last      <= 1'b0;
         r_chain     <= 1'b0;
      end else if (clear) begin
         r_state     <= LP_ST_IDLE;
         r_rem_alen  <= '0;
         r_next_addr <= '0;
         r_last      <= 1'b0;
         r_chain     <= 1'b0;
      end else if (enable) begin
         r_state     <= w_state_d;
         r_rem_alen  <= w_rem_alen_d;
         r_next_addr <= w_next_addr_d;
         r_last      <= w_last_d;
         r_chain     <= w_chain_d;
      end
   end

   // Saturating count of extra sub-bursts; survives clear
   always_ff @(posedge clk or negedge rstnn) begin
      if (!rstnn) begin
         r_split_count <= '0;
      end else if (w_run && w_split_inc && (r_split_count != 16'hFFFF)) begin
         r_split_count <= r_split_count + 16'd1;
      end
   end

   // FIFO pointers and occupancy; full status uses current occupancy only
   always_ff @(posedge clk or negedge rstnn) begin
      if (!rstnn) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else if (clear) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_wptr <= (r_wptr == LP_LAST_PTR) ? '0 : r_wptr + 1'b1;
         end
         if (w_pop) begin
            r_rptr <= (r_rptr == LP_LAST_PTR) ? '0 : r_rptr + 1'b1;
         end
         r_count <= r_count + LP_CNT_W'(w_push) - LP_CNT_W'(w_pop);
      end
   end

   // FIFO storage; contents are masked on minfo while empty
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wptr] <= w_push_data;
      end
   end

endmodule

// File: tb/tb_dca_lsu_txn_splitter.sv
// Self-checking bench: directed scenarios plus randomized traffic against a beat-level model.
module tb_dca_lsu_txn_splitter;

   localparam int TW  = 26;  // 16-bit address instance
   localparam int PTW = 42;  // pass-through instance, default widths

   logic clk = 1'b0;
   logic rstnn;
   logic clear;
   logic enable;

   logic          sinfo_valid;
   logic [TW-1:0] sinfo;
   logic          sinfo_ready;
   logic          minfo_ready;
   logic [TW-1:0] minfo;
   logic          minfo_request;
   logic          busy;
   logic [15:0]   split_count;

   logic           p_sinfo_valid;
   logic [PTW-1:0] p_sinfo;
   logic           p_sinfo_ready;
   logic           p_minfo_ready;
   logic [PTW-1:0] p_minfo;
   logic           p_minfo_request;
   logic           p_busy;
   logic [15:0]    p_split_count;

   int n_checks = 0;
   int n_errors = 0;
   int model_splits = 0;
   bit model_on = 1'b0;
   logic [TW-1:0] exp_q [$];

   always #5 clk = ~clk;

   dca_lsu_txn_splitter #(
      .BW_BITADDR (16),
      .BW_ALEN    (8),
      .BW_BEAT    (32),
      .MAX_ALEN   (15),
      .SPLIT_EN   (1),
      .FIFO_DEPTH (2)
   ) u_dut (
      .clk           (clk),
      .rstnn         (rstnn),
      .clear         (clear),
      .enable        (enable),
      .sinfo_ready   (sinfo_ready),
      .sinfo_valid   (sinfo_valid),
      .sinfo         (sinfo),
      .minfo_ready   (minfo_ready),
      .minfo         (minfo),
      .minfo_request (minfo_request),
      .busy          (busy),
      .split_count   (split_count)
   );

   dca_lsu_txn_splitter #(
      .SPLIT_EN (0)
   ) u_dut_pt (
      .clk           (clk),
      .rstnn         (rstnn),
      .clear         (clear),
      .enable        (enable),
      .sinfo_ready   (p_sinfo_ready),
      .sinfo_valid   (p_sinfo_valid),
      .sinfo         (p_sinfo),
      .minfo_ready   (p_minfo_ready),
      .minfo         (p_minfo),
      .minfo_request (p_minfo_request),
      .busy          (p_busy),
      .split_count   (p_split_count)
   );

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [TW-1:0] mk(input logic l, input logic c, input int alen,
                                        input int addr);
      return {l, c, alen[7:0], addr[15:0]};
   endfunction

   // Model: walk the burst in beats, 16 beats per legal sub-burst, 32 address bits per beat
   task automatic expand(input logic [TW-1:0] d);
      int beats;
      int off;
      beats = int'(d[23:16]) + 1;
      off   = 0;
      while (beats > 16) begin
         exp_q.push_back(mk(1'b0, 1'b1, 15, int'(d[15:0]) + off * 32));
         off   += 16;
         beats -= 16;
         model_splits++;
      end
      exp_q.push_back(mk(d[25], d[24], beats - 1, int'(d[15:0]) + off * 32));
   endtask

   // Scoreboard: every pop must match the oldest expected descriptor
   always @(negedge clk) begin
      if (rstnn) begin
         if (enable && !clear && minfo_request && minfo_ready && exp_q.size() != 0) begin
            check_val("minfo_order", minfo, exp_q[0]);
            void'(exp_q.pop_front());
         end else if (!clear && exp_q.size() == 0) begin
            check_val("minfo_ready_unexpected", minfo_ready, 0);
         end
         if (model_on && sinfo_valid && sinfo_ready) expand(sinfo);
      end
   end

   task automatic drive_one(input logic [TW-1:0] d);
      @(posedge clk); #1;
      sinfo = d;
      sinfo_valid = 1'b1;
      @(negedge clk);
      check_val("accept_ready", sinfo_ready, 1);
      @(posedge clk); #1;
      sinfo_valid = 1'b0;
   endtask

   task automatic wait_drain(input string tag, input int max_cyc);
      @(posedge clk); #1;
      minfo_request = 1'b1;
      for (int i = 0; i < max_cyc; i++) begin
         @(posedge clk);
         if (exp_q.size() == 0) break;
      end
      #1;
      minfo_request = 1'b0;
      check_val({tag, "_drained"}, exp_q.size(), 0);
      @(negedge clk);
      check_val({tag, "_empty"}, minfo_ready, 0);
      check_val({tag, "_busy"}, busy, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin
      logic [TW-1:0]  d;
      logic [PTW-1:0] pd;
      rstnn = 1'b0; clear = 1'b0; enable = 1'b1;
      sinfo_valid = 1'b1; sinfo = '0; minfo_request = 1'b0;
      p_sinfo_valid = 1'b0; p_sinfo = '0; p_minfo_request = 1'b0;

      // Reset values
      repeat (2) @(negedge clk);
      check_val("rst_sready", sinfo_ready, 0);
      check_val("rst_mready", minfo_ready, 0);
      check_val("rst_minfo", minfo, 0);
      check_val("rst_busy", busy, 0);
      check_val("rst_split", split_count, 0);
      check_val("rst_p_sready", p_sinfo_ready, 0);
      @(posedge clk); #1;
      rstnn = 1'b1;
      sinfo_valid = 1'b0;

      // Single short burst, one-cycle latency
      d = mk(1'b1, 1'b0, 7, 16'h1000);
      exp_q.push_back(d);
      drive_one(d);
      @(negedge clk);
      check_val("short_mready", minfo_ready, 1);
      check_val("short_minfo", minfo, d);
      check_val("short_split", split_count, 0);
      wait_drain("short", 20);

      // Split burst of 40 beats into 16/16/8
      @(posedge clk); #1;
      minfo_request = 1'b1;
      exp_q.push_back(mk(1'b0, 1'b1, 15, 16'h1000));
      exp_q.push_back(mk(1'b0, 1'b1, 15, 16'h1200));
      exp_q.push_back(mk(1'b1, 1'b0, 7, 16'h1400));
      drive_one(mk(1'b1, 1'b0, 39, 16'h1000));
      @(negedge clk);
      check_val("split_sready_c1", sinfo_ready, 0);
      @(posedge clk); #1;
      @(negedge clk);
      check_val("split_sready_c2", sinfo_ready, 0);
      @(posedge clk); #1;
      @(negedge clk);
      check_val("split_sready_c3", sinfo_ready, 1);
      wait_drain("split", 20);
      check_val("split_count_2", split_count, 2);

      // Backpressure with a 2-entry FIFO
      @(posedge clk); #1;
      minfo_request = 1'b0;
      exp_q.push_back(mk(1'b0, 1'b1, 15, 16'h1000));
      exp_q.push_back(mk(1'b0, 1'b1, 15, 16'h1200));
      exp_q.push_back(mk(1'b0, 1'b1, 15, 16'h1400));
      exp_q.push_back(mk(1'b1, 1'b0, 15, 16'h1600));
      drive_one(mk(1'b1, 1'b0, 63, 16'h1000));
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_val("bp_head", minfo, mk(1'b0, 1'b1, 15, 16'h1000));
         check_val("bp_busy", busy, 1);
         check_val("bp_sready", sinfo_ready, 0);
         @(posedge clk); #1;
      end
      minfo_request = 1'b1;
      @(posedge clk); #1;
      minfo_request = 1'b0;
      @(negedge clk);
      check_val("bp_head_after_pop", minfo, mk(1'b0, 1'b1, 15, 16'h1200));
      wait_drain("bp", 20);
      check_val("bp_split", split_count, 5);

      // Clear after the first sub-burst; a concurrent descriptor is dropped
      @(posedge clk); #1;
      exp_q.push_back(mk(1'b0, 1'b1, 15, 16'h3000));
      drive_one(mk(1'b1, 1'b1, 47, 16'h3000));
      clear = 1'b1;
      sinfo = mk(1'b1, 1'b1, 2, 16'h5555);
      sinfo_valid = 1'b1;
      exp_q.delete();
      @(negedge clk);
      check_val("clr_sready", sinfo_ready, 0);
      @(posedge clk); #1;
      clear = 1'b0;
      sinfo_valid = 1'b0;
      @(negedge clk);
      check_val("clr_mready", minfo_ready, 0);
      check_val("clr_busy", busy, 0);
      check_val("clr_split_kept", split_count, 6);
      d = mk(1'b0, 1'b0, 3, 16'h0020);
      exp_q.push_back(d);
      drive_one(d);
      wait_drain("post_clr", 20);

      // Address wrap in a 16-bit space
      @(posedge clk); #1;
      exp_q.push_back(mk(1'b0, 1'b1, 15, 16'hFE00));
      exp_q.push_back(mk(1'b1, 1'b0, 15, 16'h0000));
      drive_one(mk(1'b1, 1'b0, 31, 16'hFE00));
      wait_drain("wrap", 20);
      check_val("wrap_split", split_count, 7);

      // Pass-through instance and enable freeze
      pd = {1'b1, 1'b1, 8'd200, 32'hABCD_0000};
      @(posedge clk); #1;
      p_sinfo = pd;
      p_sinfo_valid = 1'b1;
      @(negedge clk);
      check_val("pt_sready", p_sinfo_ready, 1);
      @(posedge clk); #1;
      p_sinfo_valid = 1'b0;
      @(negedge clk);
      check_val("pt_mready", p_minfo_ready, 1);
      check_val("pt_minfo", p_minfo, pd);
      @(posedge clk); #1;
      enable = 1'b0;
      p_minfo_request = 1'b1;
      p_sinfo_valid = 1'b1;
      p_sinfo = {1'b0, 1'b0, 8'd5, 32'h0000_0040};
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_val("en0_sready", p_sinfo_ready, 0);
         check_val("en0_mready", p_minfo_ready, 1);
         check_val("en0_minfo", p_minfo, pd);
         @(posedge clk); #1;
      end
      enable = 1'b1;
      p_sinfo_valid = 1'b0;
      @(posedge clk); #1;
      p_minfo_request = 1'b0;
      @(negedge clk);
      check_val("pt_popped", p_minfo_ready, 0);
      check_val("pt_busy", p_busy, 0);
      check_val("pt_split", p_split_count, 0);

      // Reset asserted mid-split
      @(posedge clk); #1;
      exp_q.push_back(mk(1'b0, 1'b1, 15, 16'h0100));
      exp_q.push_back(mk(1'b0, 1'b1, 15, 16'h0300));
      drive_one(mk(1'b0, 1'b0, 63, 16'h0100));
      @(negedge clk);
      #2;
      rstnn = 1'b0;
      exp_q.delete();
      #1;
      check_val("mrst_mready", minfo_ready, 0);
      check_val("mrst_minfo", minfo, 0);
      check_val("mrst_busy", busy, 0);
      check_val("mrst_split", split_count, 0);
      check_val("mrst_sready", sinfo_ready, 0);
      @(posedge clk); #1;
      rstnn = 1'b1;
      @(negedge clk);
      check_val("mrst_after_busy", busy, 0);

      // Randomized traffic against the beat-level model
      model_splits = 0;
      model_on = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         @(posedge clk); #1;
         sinfo_valid   = ($urandom_range(0, 1) == 1);
         minfo_request = ($urandom_range(0, 9) < 6);
         enable        = ($urandom_range(0, 9) != 0);
         d = mk($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 40),
                $urandom_range(0, 65535));
         sinfo = d;
      end
      @(posedge clk); #1;
      sinfo_valid = 1'b0;
      enable = 1'b1;
      wait_drain("rand", 2000);
      check_val("rand_split", split_count, model_splits);
      model_on = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
